yi_writer: RTL

//  Write-side counterpart of the SpMV gather readers: collects result elements (Yi) from the kernel
//  on a valid/ready stream, packs them into 64-bit beats and stores them to Y memory through an AXI4

---
 rtl/spmv_pkg.sv | 43 ++++
 rtl/yi_beat_packer.sv | 84 ++++++++
 rtl/yi_writer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spmv_pkg.sv
// Shared definitions for the SpMV Y-vector write path: element width codes,
// AXI encodings, FSM state type and per-width lookup helpers.
package spmv_pkg;

  localparam logic [1:0] W16 = 2'd0;
  localparam logic [1:0] W32 = 2'd1;
  localparam logic [1:0] W64 = 2'd2;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_8B    = 3'd3;
  localparam logic [3:0] AXI_CACHE_BUF  = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } wr_state_e;

  // Code 3 is not a real width; it behaves as 64-bit.
  function automatic logic [1:0] norm_width(input logic [1:0] code);
    return (code == 2'd3) ? W64 : code;
  endfunction

  function automatic logic [2:0] lanes_of(input logic [1:0] code);
    case (code)
      W16:     return 3'd4;
      W32:     return 3'd2;
      default: return 3'd1;
    endcase
  endfunction

  // log2 of the element size in bytes.
  function automatic logic [2:0] elem_size_log2(input logic [1:0] code);
    case (code)
      W16:     return 3'd1;
      W32:     return 3'd2;
      default: return 3'd3;
    endcase
  endfunction

endpackage

// File: rtl/yi_beat_packer.sv
// Packs right-justified Yi elements into 64-bit beats with byte strobes.
// The closing beat is presented combinationally in the cycle its final element is pushed.
module yi_beat_packer
  import spmv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic [1:0]  wcode_i,
  input  logic        push_i,
  input  logic        last_i,
  input  logic [63:0] data_i,
  output logic        close_o,
  output logic [63:0] beat_data_o,
  output logic [7:0]  beat_strb_o
);

  logic [1:0]  lane_q, lane_d;
  logic [63:0] data_q, data_d;
  logic [7:0]  strb_q, strb_d;

  logic [63:0] elem_mask;
  logic [7:0]  lane_strb;
  logic [5:0]  bit_off;
  logic [2:0]  byte_off;
  logic [2:0]  lanes;

  always_comb begin
    lanes = lanes_of(wcode_i);
    case (wcode_i)
      W16: begin
        elem_mask = 64'h0000_0000_0000_FFFF;
        lane_strb = 8'h03;
        bit_off   = {lane_q, 4'd0};
      end
      W32: begin
        elem_mask = 64'h0000_0000_FFFF_FFFF;
        lane_strb = 8'h0F;
        bit_off   = {lane_q[0], 5'd0};
      end
      default: begin
        elem_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        lane_strb = 8'hFF;
        bit_off   = 6'd0;
      end
    endcase
    byte_off = bit_off[5:3];

    // Merge the incoming element into the partially filled beat.
    beat_data_o = data_q | ((data_i & elem_mask) << bit_off);
    beat_strb_o = strb_q | (lane_strb << byte_off);
    close_o     = push_i & (({1'b0, lane_q} == (lanes - 3'd1)) | last_i);
  end

  always_comb begin
    lane_d = lane_q;
    data_d = data_q;
    strb_d = strb_q;
    if (push_i) begin
      if (close_o) begin
        lane_d = 2'd0;
        data_d = 64'd0;
        strb_d = 8'd0;
      end else begin
        lane_d = lane_q + 2'd1;
        data_d = beat_data_o;
        strb_d = beat_strb_o;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      lane_q <= 2'd0;
      data_q <= 64'd0;
      strb_q <= 8'd0;
    end else begin
      lane_q <= lane_d;
      data_q <= data_d;
      strb_q <= strb_d;
    end
  end

endmodule

// File: rtl/yi_writer.sv
// Collects Yi result elements, packs them into 64-bit beats and writes them to Y memory
// as single-beat AXI4 bursts, limiting the number of writes awaiting a B response.
module yi_writer
  import spmv_pkg::*;
#(
  parameter logic [31:0] YVAL_BASE_ADDR  = 32'h4000_0000,
  parameter int          MAX_OUTSTANDING = 4,
  parameter int          ADDR_WIDTH      = 48
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Write_Begin,
  input  logic [31:0]           Write_Length,
  input  logic [1:0]            Ctrl_sig_Y,
  input  logic                  Yi_valid,
  output logic                  Yi_ready,
  input  logic [63:0]           Yi_data,
  output logic                  Write_Done,
  output logic                  Write_Err,
  output logic [0:0]            m_axi_Yi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_Yi_awaddr,
  output logic [7:0]            m_axi_Yi_awlen,
  output logic [2:0]            m_axi_Yi_awsize,
  output logic [1:0]            m_axi_Yi_awburst,
  output logic                  m_axi_Yi_awlock,
  output logic [3:0]            m_axi_Yi_awcache,
  output logic [2:0]            m_axi_Yi_awprot,
  output logic [3:0]            m_axi_Yi_awqos,
  output logic                  m_axi_Yi_awvalid,
  input  logic                  m_axi_Yi_awready,
  output logic [63:0]           m_axi_Yi_wdata,
  output logic [7:0]            m_axi_Yi_wstrb,
  output logic                  m_axi_Yi_wlast,
  output logic                  m_axi_Yi_wvalid,
  input  logic                  m_axi_Yi_wready,
  input  logic [0:0]            m_axi_Yi_bid,
  input  logic [1:0]            m_axi_Yi_bresp,
  input  logic                  m_axi_Yi_bvalid,
  output logic                  m_axi_Yi_bready
);

  localparam logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(YVAL_BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(8);
  localparam logic [3:0]            MAX_OUT    = 4'(MAX_OUTSTANDING);

  wr_state_e state_q, state_d;

  logic [31:0]           len_q, len_d;
  logic [1:0]            wcode_q, wcode_d;
  logic [31:0]           acc_q, acc_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            outst_q, outst_d;
  logic                  err_q, err_d;
  logic                  pend_q, pend_d;
  logic                  issued_q, issued_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [63:0]           wdata_q, wdata_d;
  logic [7:0]            wstrb_q, wstrb_d;

  logic        start, push, last_elem, slot;
  logic        aw_hs, w_hs, b_hs, pend_clr;
  logic        close;
  logic [63:0] beat_data;
  logic [7:0]  beat_strb;

  assign start     = (state_q == ST_IDLE) && Write_Begin;
  assign push      = Yi_valid && Yi_ready;
  assign last_elem = (acc_q == (len_q - 32'd1));
  assign slot      = (outst_q < MAX_OUT);
  assign aw_hs     = awvalid_q && m_axi_Yi_awready;
  assign w_hs      = wvalid_q && m_axi_Yi_wready;
  assign b_hs      = m_axi_Yi_bvalid && m_axi_Yi_bready;
  // A beat retires once both its address and data have been accepted, in either order.
  assign pend_clr  = pend_q && (aw_hs || aw_done_q) && (w_hs || w_done_q);

  yi_beat_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (start),
    .wcode_i     (wcode_q),
    .push_i      (push),
    .last_i      (last_elem),
    .data_i      (Yi_data),
    .close_o     (close),
    .beat_data_o (beat_data),
    .beat_strb_o (beat_strb)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (Write_Begin) state_d = (Write_Length == 32'd0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (pend_clr && (acc_q == len_q)) state_d = ST_DRAIN;
      ST_DRAIN: if (outst_q == 4'd0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    Yi_ready        = 1'b0;
    m_axi_Yi_bready = 1'b0;
    Write_Done      = 1'b0;
    case (state_q)
      ST_RUN: begin
        Yi_ready        = !pend_q && (acc_q < len_q);
        m_axi_Yi_bready = 1'b1;
      end
      ST_DRAIN: m_axi_Yi_bready = 1'b1;
      ST_DONE: begin
        m_axi_Yi_bready = 1'b1;
        Write_Done      = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    len_d     = len_q;
    wcode_d   = wcode_q;
    acc_d     = acc_q;
    addr_d    = addr_q;
    outst_d   = outst_q;
    err_d     = err_q;
    pend_d    = pend_q;
    issued_d  = issued_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;

    if (start) begin
      len_d   = Write_Length;
      wcode_d = norm_width(Ctrl_sig_Y);
      acc_d   = 32'd0;
      addr_d  = BASE_ADDR;
      err_d   = 1'b0;
    end

    if (push) acc_d = acc_q + 32'd1;

    // A closed beat issues at once when a slot is free, otherwise waits for a B to free one.
    if (push && close) begin
      pend_d   = 1'b1;
      awaddr_d = addr_q;
      addr_d   = addr_q + BEAT_BYTES;
      wdata_d  = beat_data;
      wstrb_d  = beat_strb;
      if (slot) begin
        awvalid_d = 1'b1;
        wvalid_d  = 1'b1;
        issued_d  = 1'b1;
      end
    end else if (pend_q && !issued_q && slot) begin
      awvalid_d = 1'b1;
      wvalid_d  = 1'b1;
      issued_d  = 1'b1;
    end

    if (aw_hs) begin
      awvalid_d = 1'b0;
      aw_done_d = 1'b1;
    end
    if (w_hs) begin
      wvalid_d = 1'b0;
      w_done_d = 1'b1;
    end
    if (pend_clr) begin
      pend_d    = 1'b0;
      issued_d  = 1'b0;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
    end

    case ({aw_hs, b_hs})
      2'b10:   outst_d = outst_q + 4'd1;
      2'b01:   outst_d = outst_q - 4'd1;
      default: ;
    endcase

    if (b_hs && (m_axi_Yi_bresp != AXI_RESP_OKAY)) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q     <= 32'd0;
      wcode_q   <= W16;
      acc_q     <= 32'd0;
      addr_q    <= '0;
      outst_q   <= 4'd0;
      err_q     <= 1'b0;
      pend_q    <= 1'b0;
      issued_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= 64'd0;
      wstrb_q   <= 8'd0;
    end else begin
      len_q     <= len_d;
      wcode_q   <= wcode_d;
      acc_q     <= acc_d;
      addr_q    <= addr_d;
      outst_q   <= outst_d;
      err_q     <= err_d;
      pend_q    <= pend_d;
      issued_q  <= issued_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  assign Write_Err        = err_q;
  assign m_axi_Yi_awid    = 1'b0;
  assign m_axi_Yi_awaddr  = awaddr_q;
  assign m_axi_Yi_awlen   = 8'd0;
  assign m_axi_Yi_awsize  = AXI_SIZE_8B;
  assign m_axi_Yi_awburst = AXI_BURST_INCR;
  assign m_axi_Yi_awlock  = 1'b0;
  assign m_axi_Yi_awcache = AXI_CACHE_BUF;
  assign m_axi_Yi_awprot  = 3'd0;
  assign m_axi_Yi_awqos   = 4'd0;
  assign m_axi_Yi_awvalid = awvalid_q;
  assign m_axi_Yi_wdata   = wdata_q;
  assign m_axi_Yi_wstrb   = wstrb_q;
  assign m_axi_Yi_wlast   = 1'b1;
  assign m_axi_Yi_wvalid  = wvalid_q;

  logic unused_bid;
  assign unused_bid = m_axi_Yi_bid[0];

endmodule
